// File: rtl/de10lite_vga_timing_if.sv
// Pixel fetch bus between the VGA timing stage (master) and an upstream pixel source (slave).
// pix_req_o is a one-clk strobe with pix_x_o/pix_y_o valid while it is high; there is no ready,
// so the source must hold pix_rgb_i stable at the next pixel-enable edge (2 clk after the request edge).
interface de10lite_vga_timing_if;
  logic        pix_req_o;
  logic [9:0]  pix_x_o;
  logic [9:0]  pix_y_o;
  logic [11:0] pix_rgb_i;

  modport master (output pix_req_o, output pix_x_o, output pix_y_o, input pix_rgb_i);
  modport slave  (input pix_req_o, input pix_x_o, input pix_y_o, output pix_rgb_i);
endinterface

// File: rtl/de10lite_vga_timing.sv
// 640x480@60 VGA timing from a 50 MHz clock with a 25 MHz pixel enable; fetches pixels through
// a fixed-latency request bus and drives registered colour and active-low sync pins.
module de10lite_vga_timing #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  de10lite_vga_timing_if.master         pix,
  output logic                          frame_o,
  output logic [3:0]                    VGA_R,
  output logic [3:0]                    VGA_G,
  output logic [3:0]                    VGA_B,
  output logic                          VGA_HS,
  output logic                          VGA_VS
);

  localparam logic [9:0] H_TOT   = 10'(H_ACT + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_TOT   = 10'(V_ACT + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] H_ACT_W = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W = 10'(V_ACT);
  localparam logic [9:0] HS_BEG  = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACT + V_FP + V_SYNC);

  logic       pe;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       wrap;
  logic       active, hs, vs;
  logic       act_d, hs_d, vs_d;

  always_comb begin
    active = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
    hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    h_nxt  = h_cnt + 10'd1;
    v_nxt  = v_cnt;
    wrap   = 1'b0;
    if (h_cnt == H_TOT - 10'd1) begin
      h_nxt = '0;
      if (v_cnt == V_TOT - 10'd1) begin
        v_nxt = '0;
        wrap  = 1'b1;
      end else begin
        v_nxt = v_cnt + 10'd1;
      end
    end
  end

  assign pix.pix_req_o = pe && active && en_i;
  assign pix.pix_x_o   = h_cnt;
  assign pix.pix_y_o   = v_cnt;

  // Disable is handled like a synchronous reset so a re-enable restarts exactly as after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe      <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      act_d   <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      frame_o <= 1'b0;
      VGA_R   <= '0;
      VGA_G   <= '0;
      VGA_B   <= '0;
      VGA_HS  <= 1'b1;
      VGA_VS  <= 1'b1;
    end else if (!en_i) begin
      pe      <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      act_d   <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      frame_o <= 1'b0;
      VGA_R   <= '0;
      VGA_G   <= '0;
      VGA_B   <= '0;
      VGA_HS  <= 1'b1;
      VGA_VS  <= 1'b1;
    end else begin
      pe      <= ~pe;
      frame_o <= 1'b0;
      if (pe) begin
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
        frame_o <= wrap;
        act_d   <= active;
        hs_d    <= hs;
        vs_d    <= vs;
        // Pixel data requested at the previous pe edge is captured here, aligned with its syncs.
        VGA_R   <= act_d ? pix.pix_rgb_i[11:8] : 4'd0;
        VGA_G   <= act_d ? pix.pix_rgb_i[7:4]  : 4'd0;
        VGA_B   <= act_d ? pix.pix_rgb_i[3:0]  : 4'd0;
        VGA_HS  <= ~hs_d;
        VGA_VS  <= ~vs_d;
      end
    end
  end

endmodule

// File: tb/tb_de10lite_vga_timing.sv
// Directed bench for de10lite_vga_timing using a shrunken raster (16x9 totals, 8x4 active)
// so whole frames fit in a short run; expectations come from a closed-form raster model.
module tb_de10lite_vga_timing;
  localparam int HA = 8,  HF = 2, HS_W = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS_W = 2, VB = 2;
  localparam int HT = HA + HF + HS_W + HB;   // 16 pixels per line
  localparam int VT = VA + VF + VS_W + VB;   // 9 lines per frame
  localparam int FR = HT * VT;               // 144 pixels per frame

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic frame;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs;

  de10lite_vga_timing_if pix_bus ();

  de10lite_vga_timing #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS_W), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS_W), .V_BP(VB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pix(pix_bus),
    .frame_o(frame), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;             // clk edges since reset release / re-enable
  logic src_xy = 1'b0;   // 0: constant colour source, 1: {x,y,5} source
  logic have_pend = 1'b0;
  logic [11:0] pend = '0;

  typedef struct {
    int          k;
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        frame;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Source returns the pixel one negedge after it sees the request, so the value is
  // stable across the following pe edge and changes only after it.
  task automatic src_update();
    if (src_xy) begin
      if (have_pend) begin
        pix_bus.pix_rgb_i = pend;
        have_pend = 1'b0;
      end
      if (pix_bus.pix_req_o) begin
        pend = {pix_bus.pix_x_o[3:0], pix_bus.pix_y_o[3:0], 4'h5};
        have_pend = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
    src_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    k = 0;
    have_pend = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, pix_bus.pix_req_o, 1'b0);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    chk({tag, "_hs"}, vga_hs, 1'b1);
    chk({tag, "_vs"}, vga_vs, 1'b1);
    chk({tag, "_frame"}, frame, 1'b0);
    chk({tag, "_xy"}, {pix_bus.pix_x_o, pix_bus.pix_y_o}, 20'd0);
  endtask

  // Counter sits on pixel k/2; pins show pixel k/2-2 once k>=4; requests only on odd k.
  task automatic check_model(input string tag);
    int p, h, v, q, hq, vq;
    logic e_req, e_hs, e_vs, e_fr;
    logic [11:0] e_rgb;
    p = k / 2;
    h = p % HT;
    v = (p / HT) % VT;
    e_req = (k % 2 == 1) && (h < HA) && (v < VA);
    chk({tag, "_req"}, pix_bus.pix_req_o, e_req);
    if (e_req) begin
      chk({tag, "_x"}, pix_bus.pix_x_o, 10'(h));
      chk({tag, "_y"}, pix_bus.pix_y_o, 10'(v));
    end
    e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
    if (k >= 4) begin
      q  = p - 2;
      hq = q % HT;
      vq = (q / HT) % VT;
      if (hq < HA && vq < VA) e_rgb = {4'(hq), 4'(vq), 4'h5};
      e_hs = !(hq >= HA + HF && hq < HA + HF + HS_W);
      e_vs = !(vq >= VA + VF && vq < VA + VF + VS_W);
    end
    e_fr = (k % 2 == 0) && (k > 0) && (p % FR == 0);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, e_rgb);
    chk({tag, "_hs"}, vga_hs, e_hs);
    chk({tag, "_vs"}, vga_vs, e_vs);
    chk({tag, "_frame"}, frame, e_fr);
  endtask

  int ti, n_req, n_hs_low, n_vs_low, n_frame;
  int last_hs_fall, last_vs_fall, last_frame_k, last_x, last_y, max_x, max_y;
  logic prev_hs, prev_vs;

  initial begin
    //           k    req x  y  rgb      hs vs frame
    tbl[0]  = '{1,   1, 0, 0, 12'h000, 1, 1, 0};
    tbl[1]  = '{3,   1, 1, 0, 12'h000, 1, 1, 0};
    tbl[2]  = '{4,   0, 0, 0, 12'h005, 1, 1, 0};
    tbl[3]  = '{15,  1, 7, 0, 12'h505, 1, 1, 0};
    tbl[4]  = '{17,  0, 0, 0, 12'h605, 1, 1, 0};
    tbl[5]  = '{23,  0, 0, 0, 12'h000, 1, 1, 0};
    tbl[6]  = '{24,  0, 0, 0, 12'h000, 0, 1, 0};
    tbl[7]  = '{29,  0, 0, 0, 12'h000, 0, 1, 0};
    tbl[8]  = '{30,  0, 0, 0, 12'h000, 1, 1, 0};
    tbl[9]  = '{33,  1, 0, 1, 12'h000, 1, 1, 0};
    tbl[10] = '{37,  1, 2, 1, 12'h015, 1, 1, 0};
    tbl[11] = '{114, 0, 0, 0, 12'h735, 1, 1, 0};
    tbl[12] = '{163, 0, 0, 0, 12'h000, 1, 1, 0};
    tbl[13] = '{164, 0, 0, 0, 12'h000, 1, 0, 0};
    tbl[14] = '{227, 0, 0, 0, 12'h000, 1, 0, 0};
    tbl[15] = '{228, 0, 0, 0, 12'h000, 1, 1, 0};
    tbl[16] = '{287, 0, 0, 0, 12'h000, 1, 1, 0};
    tbl[17] = '{288, 0, 0, 0, 12'h000, 1, 1, 1};
    tbl[18] = '{289, 1, 0, 0, 12'h000, 1, 1, 0};
    tbl[19] = '{292, 0, 0, 0, 12'h005, 1, 1, 0};

    // Reset with a constant white source: pins idle, first colour 4 clk after release.
    pix_bus.pix_rgb_i = 12'hFFF;
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (k == 1) chk("first_req", pix_bus.pix_req_o, 1'b1);
      if ({vga_r, vga_g, vga_b} != 12'h000) break;
    end
    chk("first_rgb_edge", k, 4);
    chk("first_rgb_val", {vga_r, vga_g, vga_b}, 12'hFFF);

    // Two free-running frames against the raster model plus the vector table.
    src_xy = 1'b1;
    do_reset();
    ti = 0; n_req = 0; n_hs_low = 0; n_vs_low = 0; n_frame = 0;
    last_hs_fall = -1; last_vs_fall = -1; last_frame_k = -1;
    last_x = -1; last_y = -1; max_x = 0; max_y = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i < 2 * 2 * FR; i++) begin
      tick();
      check_model("run");
      if (ti < 20 && tbl[ti].k == k) begin
        chk("tbl_req", pix_bus.pix_req_o, tbl[ti].req);
        if (tbl[ti].req) chk("tbl_xy", {pix_bus.pix_x_o, pix_bus.pix_y_o}, {tbl[ti].x, tbl[ti].y});
        chk("tbl_rgb", {vga_r, vga_g, vga_b}, tbl[ti].rgb);
        chk("tbl_hs", vga_hs, tbl[ti].hs);
        chk("tbl_vs", vga_vs, tbl[ti].vs);
        chk("tbl_frame", frame, tbl[ti].frame);
        ti++;
      end
      if (pix_bus.pix_req_o) begin
        n_req++;
        if (int'(pix_bus.pix_x_o) > max_x) max_x = int'(pix_bus.pix_x_o);
        if (int'(pix_bus.pix_y_o) > max_y) max_y = int'(pix_bus.pix_y_o);
        if (k <= 2 * FR) begin
          last_x = int'(pix_bus.pix_x_o);
          last_y = int'(pix_bus.pix_y_o);
        end
      end
      if (!vga_hs) n_hs_low++;
      if (!vga_vs) n_vs_low++;
      if (prev_hs && !vga_hs) begin
        if (last_hs_fall >= 0) chk("hs_period", k - last_hs_fall, 2 * HT);
        last_hs_fall = k;
      end
      if (prev_vs && !vga_vs) begin
        if (last_vs_fall >= 0) chk("vs_period", k - last_vs_fall, 2 * FR);
        last_vs_fall = k;
      end
      if (frame) begin
        n_frame++;
        if (last_frame_k >= 0) chk("frame_period", k - last_frame_k, 2 * FR);
        last_frame_k = k;
      end
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
    chk("table_applied", ti, 20);
    chk("req_count_2fr", n_req, 2 * HA * VA);
    chk("last_req_fr1", {last_x, last_y}, {32'(HA - 1), 32'(VA - 1)});
    chk("max_x", max_x, HA - 1);
    chk("max_y", max_y, VA - 1);
    chk("hs_low_clk", n_hs_low, 18 * 2 * HS_W);
    chk("vs_low_clk", n_vs_low, 2 * 2 * VS_W * HT);
    chk("frame_count", n_frame, 2);

    // Disable at h=12, v=5 (inside HS and VS) on a cycle whose next edge is a pe edge.
    do_reset();
    for (int i = 0; i < 2 * (5 * HT + 12) + 1; i++) begin
      tick();
      check_model("pre_dis");
    end
    chk("pre_dis_vs_low", vga_vs, 1'b0);
    en = 1'b0;
    chk("dis_req_now", pix_bus.pix_req_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("disabled");
    end
    en = 1'b1;
    k = 0;
    have_pend = 1'b0;
    for (int i = 0; i < 41; i++) begin
      tick();
      check_model("reen");
    end

    // Async reset mid active line (h=4, v=1, request high), held 3 clk.
    chk("pre_rst_req", pix_bus.pix_req_o, 1'b1);
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    repeat (3) @(negedge clk);
    chk_idle("held_rst");
    rst = 1'b0;
    k = 0;
    have_pend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_model("post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
